cps_counter_mc: RTL and testbench

CPS_COUNTER_MC -- requirements
Module: cps_counter_mc

---
 rtl/cps_pkg.sv | 15 +
 rtl/cps_edge_sync.sv | 37 +++
 rtl/cps_counter_mc.sv | 155 +++++++++++++++
 tb/tb_cps_counter_mc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cps_pkg.sv
// Package for the multi-channel gated event counter.
// Holds the default channel count, count width and window length, plus a
// helper that sizes the gate timer from the window length.
package cps_pkg;

   localparam int unsigned NCH_DEF         = 4;
   localparam int unsigned CW_DEF          = 16;
   localparam int unsigned GATE_CYCLES_DEF = 67108864;

   // Timer width: enough bits to hold 0 .. gate-1.
   function automatic int unsigned timer_width(input int unsigned gate);
      return $clog2(gate);
   endfunction

endpackage

// File: rtl/cps_edge_sync.sv
// One trigger channel: 2-flop synchroniser plus rising-edge detector.
// Ports:
//   clk    - sole clock
//   reset  - asynchronous active-low reset
//   trg    - asynchronous event input
//   pulse  - registered one-cycle pulse per synchronised rising edge
module cps_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic trg,
   output logic pulse
);

   logic [1:0] sync;
   logic       prev;
   logic [1:0] warm;

   // The sync flops come out of reset as 0, so the edge detector stays
   // disarmed until prev holds a genuine sample of trg; a trigger held high
   // through reset release therefore never looks like a rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync  <= '0;
         prev  <= 1'b0;
         warm  <= '0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], trg};
         prev  <= sync[1];
         if (warm != 2'd3) begin
            warm <= warm + 2'd1;
         end
         pulse <= (warm == 2'd3) && sync[1] && !prev;
      end
   end

endmodule

// File: rtl/cps_counter_mc.sv
// Multi-channel gated event counter.
// Each channel counts synchronised trigger edges over a fixed window of
// GATE_CYCLES clocks; at the end of each window the saturating counts and
// saturation flags are latched and flagged to a consumer with valid/ack.
// Ports:
//   clk      - sole clock
//   reset    - asynchronous active-low reset
//   trg      - NCH asynchronous event inputs
//   clr      - synchronous window restart
//   ack      - consumer acknowledge of the held result
//   cnt      - latched counts, channel i at [i*CW +: CW]
//   sat      - latched per-channel saturation flags
//   valid    - result held and not yet acknowledged
//   overrun  - a new result replaced an unacknowledged one
//   wflag    - one-cycle pulse on every result update
module cps_counter_mc
   import cps_pkg::*;
#(
   parameter int unsigned NCH         = NCH_DEF,
   parameter int unsigned CW          = CW_DEF,
   parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    trg,
   input  logic              clr,
   input  logic              ack,
   output logic [NCH*CW-1:0] cnt,
   output logic [NCH-1:0]    sat,
   output logic              valid,
   output logic              overrun,
   output logic              wflag
);

   localparam int unsigned    TW   = timer_width(GATE_CYCLES);
   localparam logic [TW-1:0]  TERM = TW'(GATE_CYCLES - 1);

   logic [NCH-1:0]    pulse;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     timer_nx;
   logic [CW-1:0]     acc      [NCH];
   logic [CW-1:0]     acc_nx   [NCH];
   logic [CW-1:0]     bumped   [NCH];
   logic [NCH-1:0]    at_max;
   logic [NCH-1:0]    hit;
   logic [NCH-1:0]    sticky;
   logic [NCH-1:0]    sticky_nx;
   logic [NCH*CW-1:0] cnt_nx;
   logic [NCH-1:0]    sat_nx;
   logic              valid_nx;
   logic              overrun_nx;
   logic              wflag_nx;
   logic              terminal;
   logic              update;

   // Per-channel synchroniser and edge detector.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      cps_edge_sync u_sync (
         .clk   (clk),
         .reset (reset),
         .trg   (trg[g]),
         .pulse (pulse[g])
      );
   end

   assign terminal = (timer == TERM);
   // clr wins over the terminal-cycle latch.
   assign update   = terminal && !clr;

   // Saturating increment of each accumulator by its edge pulse.
   always_comb begin
      at_max = '0;
      hit    = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         at_max[i] = (acc[i] == {CW{1'b1}});
         hit[i]    = pulse[i] & at_max[i];
         bumped[i] = (pulse[i] && !at_max[i]) ? acc[i] + CW'(1) : acc[i];
      end
   end

   // Next-state for timer, accumulators and result registers.
   always_comb begin
      timer_nx   = terminal ? '0 : timer + TW'(1);
      acc_nx     = acc;
      sticky_nx  = sticky;
      cnt_nx     = cnt;
      sat_nx     = sat;
      valid_nx   = valid;
      overrun_nx = overrun;
      wflag_nx   = update;

      for (int unsigned i = 0; i < NCH; i++) begin
         if (terminal) begin
            // A pulse in the terminal cycle belongs to the closing window.
            cnt_nx[i*CW +: CW] = bumped[i];
            sat_nx[i]          = sticky[i] | hit[i];
            acc_nx[i]          = '0;
            sticky_nx[i]       = 1'b0;
         end else begin
            acc_nx[i]    = bumped[i];
            sticky_nx[i] = sticky[i] | hit[i];
         end
      end

      if (clr) begin
         timer_nx  = '0;
         sticky_nx = '0;
         cnt_nx    = cnt;
         sat_nx    = sat;
         for (int unsigned i = 0; i < NCH; i++) begin
            acc_nx[i] = '0;
         end
      end

      if (update) begin
         valid_nx = 1'b1;
      end else if (ack) begin
         valid_nx = 1'b0;
      end

      if (update && valid && !ack) begin
         overrun_nx = 1'b1;
      end else if (ack) begin
         overrun_nx = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer   <= '0;
         sticky  <= '0;
         cnt     <= '0;
         sat     <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
         wflag   <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) begin
            acc[i] <= '0;
         end
      end else begin
         timer   <= timer_nx;
         sticky  <= sticky_nx;
         cnt     <= cnt_nx;
         sat     <= sat_nx;
         valid   <= valid_nx;
         overrun <= overrun_nx;
         wflag   <= wflag_nx;
         for (int unsigned i = 0; i < NCH; i++) begin
            acc[i] <= acc_nx[i];
         end
      end
   end

endmodule

// File: tb/tb_cps_counter_mc.sv
// Directed testbench for cps_counter_mc (4 channels, 8-bit counts).
// The window is long enough to fit 300 edges at the 2-cycle minimum spacing.
module tb_cps_counter_mc;

   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 8;
   localparam int          G   = 700;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    trg = '0;
   logic              clr = 1'b0;
   logic              ack = 1'b0;
   logic [NCH*CW-1:0] cnt;
   logic [NCH-1:0]    sat;
   logic              valid;
   logic              overrun;
   logic              wflag;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;
   int last   = 0;

   cps_counter_mc #(
      .NCH         (NCH),
      .CW          (CW),
      .GATE_CYCLES (G)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .trg     (trg),
      .clr     (clr),
      .ack     (ack),
      .cnt     (cnt),
      .sat     (sat),
      .valid   (valid),
      .overrun (overrun),
      .wflag   (wflag)
   );

   always #5 clk = ~clk;

   // Number of rising clock edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Returns at the first negedge where wflag is high, or ok=0 after budget.
   task automatic wait_wflag(input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wflag === 1'b1) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   // Advance to just after rising edge number target.
   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges on each channel, one every 2 cycles, starting at the next edge.
   task automatic drive_edges(input int n0, input int n1, input int n2, input int n3);
      int mx;
      logic [NCH-1:0] m;
      mx = n0;
      if (n1 > mx) mx = n1;
      if (n2 > mx) mx = n2;
      if (n3 > mx) mx = n3;
      for (int k = 0; k < mx; k++) begin
         m[0] = (k < n0);
         m[1] = (k < n1);
         m[2] = (k < n2);
         m[3] = (k < n3);
         @(posedge clk);
         #1 trg = m;
         @(posedge clk);
         #1 trg = '0;
      end
   endtask

   task automatic do_ack();
      @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
   endtask

   task automatic test_reset();
      int rel, at;
      bit ok;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h expected %h", cnt, 32'h0); end
      checks++; if (sat !== 4'h0) begin errors++; $display("FAIL reset_sat: got %b expected %b", sat, 4'h0); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (wflag !== 1'b0) begin errors++; $display("FAIL reset_wflag: got %b expected 0", wflag); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      rel = cyc;
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok) begin errors++; $display("FAIL first_window_timeout: got no wflag expected wflag"); end
      checks++; if (at !== rel + G) begin errors++; $display("FAIL first_window_len: got %0d expected %0d", at - rel, G); end
      checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL first_window_cnt: got %h expected %h", cnt, 32'h0); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_window_valid: got %b expected 1", valid); end
      last = at;
      @(negedge clk);
      checks++; if (wflag !== 1'b0) begin errors++; $display("FAIL wflag_width: got %b expected 0", wflag); end
   endtask

   task automatic test_counts();
      int at;
      bit ok;
      do_ack();
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b expected 0", valid); end
      drive_edges(10, 0, 37, 99);
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || at !== last + G) begin errors++; $display("FAIL counts_wflag: got %0d expected %0d", at, last + G); end
      checks++; if (cnt !== {8'd99, 8'd37, 8'd0, 8'd10}) begin errors++; $display("FAIL counts_cnt: got %h expected %h", cnt, {8'd99, 8'd37, 8'd0, 8'd10}); end
      checks++; if (sat !== 4'b0000) begin errors++; $display("FAIL counts_sat: got %b expected 0000", sat); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL counts_valid: got %b expected 1", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL counts_overrun: got %b expected 0", overrun); end
      last = at;
   endtask

   task automatic test_saturation();
      int at;
      bit ok;
      do_ack();
      drive_edges(0, 0, 300, 0);
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: got no wflag expected wflag"); end
      checks++; if (cnt !== {8'd0, 8'd255, 8'd0, 8'd0}) begin errors++; $display("FAIL sat_cnt: got %h expected %h", cnt, {8'd0, 8'd255, 8'd0, 8'd0}); end
      checks++; if (sat !== 4'b0100) begin errors++; $display("FAIL sat_flag: got %b expected 0100", sat); end
      do_ack();
      drive_edges(0, 0, 5, 0);
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_next_timeout: got no wflag expected wflag"); end
      checks++; if (cnt !== {8'd0, 8'd5, 8'd0, 8'd0}) begin errors++; $display("FAIL sat_next_cnt: got %h expected %h", cnt, {8'd0, 8'd5, 8'd0, 8'd0}); end
      checks++; if (sat !== 4'b0000) begin errors++; $display("FAIL sat_next_flag: got %b expected 0000", sat); end
      last = at;
   endtask

   // Channel 0 edge lands in the terminal cycle, channel 1 edge one cycle later.
   task automatic test_terminal_edge();
      int at;
      bit ok;
      do_ack();
      wait_until(last + G - 4);
      trg = 4'b0001;
      wait_until(last + G - 3);
      trg = 4'b0011;
      wait_until(last + G - 2);
      trg = 4'b0000;
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || at !== last + G) begin errors++; $display("FAIL term_wflag: got %0d expected %0d", at, last + G); end
      checks++; if (cnt !== {8'd0, 8'd0, 8'd0, 8'd1}) begin errors++; $display("FAIL term_closing_cnt: got %h expected %h", cnt, {8'd0, 8'd0, 8'd0, 8'd1}); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL term_overrun: got %b expected 0", overrun); end
      last = at;
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok) begin errors++; $display("FAIL term_next_timeout: got no wflag expected wflag"); end
      checks++; if (cnt !== {8'd0, 8'd0, 8'd1, 8'd0}) begin errors++; $display("FAIL term_next_cnt: got %h expected %h", cnt, {8'd0, 8'd0, 8'd1, 8'd0}); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", valid); end
      last = at;
   endtask

   task automatic test_overrun();
      int at;
      bit ok;
      do_ack();
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid: got %b expected 0", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_overrun: got %b expected 0", overrun); end
      do_ack();
      @(negedge clk);
      checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL idle_ack: got valid=%b overrun=%b expected 0 0", valid, overrun); end
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got valid=%b overrun=%b expected 1 0", valid, overrun); end
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || overrun !== 1'b1) begin errors++; $display("FAIL ovr_second: got overrun=%b expected 1", overrun); end
      last = at;
      wait_until(last + G - 1);
      ack = 1'b1;
      wait_until(last + G);
      ack = 1'b0;
      @(negedge clk);
      checks++; if (wflag !== 1'b1) begin errors++; $display("FAIL ack_upd_wflag: got %b expected 1", wflag); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ack_upd_valid: got %b expected 1", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ack_upd_overrun: got %b expected 0", overrun); end
      last = last + G;
   endtask

   task automatic test_clr();
      int at, e;
      bit ok;
      drive_edges(0, 0, 6, 0);
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || cnt !== {8'd0, 8'd6, 8'd0, 8'd0}) begin errors++; $display("FAIL clr_pre_cnt: got %h expected %h", cnt, {8'd0, 8'd6, 8'd0, 8'd0}); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_pre_overrun: got %b expected 1", overrun); end
      e = at;
      drive_edges(7, 0, 0, 0);
      wait_until(e + 50);
      clr = 1'b1;
      wait_until(e + 51);
      clr = 1'b0;
      @(negedge clk);
      checks++; if (cnt !== {8'd0, 8'd6, 8'd0, 8'd0}) begin errors++; $display("FAIL clr_keep_cnt: got %h expected %h", cnt, {8'd0, 8'd6, 8'd0, 8'd0}); end
      checks++; if (valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL clr_keep_flags: got valid=%b overrun=%b expected 1 1", valid, overrun); end
      drive_edges(0, 3, 0, 0);
      wait_wflag(G + 60, at, ok);
      checks++; if (!ok || at !== e + 51 + G) begin errors++; $display("FAIL clr_restart: got %0d expected %0d", at, e + 51 + G); end
      checks++; if (cnt !== {8'd0, 8'd0, 8'd3, 8'd0}) begin errors++; $display("FAIL clr_post_cnt: got %h expected %h", cnt, {8'd0, 8'd0, 8'd3, 8'd0}); end
      last = at;
   endtask

   task automatic test_clr_hold();
      int at, r, seen;
      bit ok;
      seen = 0;
      clr = 1'b1;
      drive_edges(0, 0, 0, 20);
      for (int i = 0; i < G; i++) begin
         @(negedge clk);
         if (wflag === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL clr_hold_wflag: got %0d pulses expected 0", seen); end
      @(posedge clk);
      #1 clr = 1'b0;
      r = cyc;
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || at !== r + G) begin errors++; $display("FAIL clr_hold_release: got %0d expected %0d", at, r + G); end
      checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL clr_hold_cnt: got %h expected %h", cnt, 32'h0); end
      last = at;
   endtask

   task automatic test_reset_mid();
      int at, rel;
      bit ok;
      drive_edges(4, 4, 4, 4);
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || cnt !== 32'h04040404) begin errors++; $display("FAIL rmid_pre_cnt: got %h expected %h", cnt, 32'h04040404); end
      last = at;
      wait_until(last + 30);
      trg = 4'hF;
      wait_until(last + 40);
      #2 reset = 1'b0;
      #1;
      checks++; if (cnt !== 32'h0 || sat !== 4'h0) begin errors++; $display("FAIL rmid_cnt: got cnt=%h sat=%b expected 0", cnt, sat); end
      checks++; if (valid !== 1'b0 || overrun !== 1'b0 || wflag !== 1'b0) begin errors++; $display("FAIL rmid_flags: got valid=%b overrun=%b wflag=%b expected 0 0 0", valid, overrun, wflag); end
      wait_until(last + 43);
      reset = 1'b1;
      rel = cyc;
      wait_wflag(G + 20, at, ok);
      checks++; if (!ok || at !== rel + G) begin errors++; $display("FAIL rmid_window: got %0d expected %0d", at, rel + G); end
      checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL rmid_held_trg: got %h expected %h", cnt, 32'h0); end
      checks++; if (overrun !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL rmid_post_flags: got valid=%b overrun=%b expected 1 0", valid, overrun); end
      trg = '0;
   endtask

   initial begin
      test_reset();
      test_counts();
      test_saturation();
      test_terminal_edge();
      test_overrun();
      test_clr();
      test_clr_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
